// File: rtl/frame_stream_pkg.sv
// Shared definitions for the frame stream controller: command opcodes,
// the frame header tag and the sequencer state encoding.
package frame_stream_pkg;

  localparam logic [3:0] OP_SET_PIX = 4'h1;
  localparam logic [3:0] OP_START   = 4'h2;
  localparam logic [3:0] OP_STOP    = 4'h3;
  localparam logic [3:0] OP_SET_GAP = 4'h4;

  localparam logic [7:0] HDR_TAG = 8'hA5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

endpackage

// File: rtl/fsc_cmd_decode.sv
// Combinational command decoder for frame_stream_ctrl.
// Ports:
//   cmd_data   - head word of the command FIFO (opcode in [31:28])
//   cmd_empty  - command FIFO empty
//   cmd_rd_en  - registered pop pulse from the top (blocks back-to-back pops)
//   state      - current sequencer state
//   accept     - head command is taken this cycle
//   op_*       - one-hot opcode strobes, qualified by accept
//   op_bad     - accepted command with an unknown opcode
module fsc_cmd_decode
  import frame_stream_pkg::*;
(
  input  logic [31:0] cmd_data,
  input  logic        cmd_empty,
  input  logic        cmd_rd_en,
  input  state_t      state,
  output logic        accept,
  output logic        op_set_pix,
  output logic        op_start,
  output logic        op_stop,
  output logic        op_set_gap,
  output logic        op_bad
);

  logic [3:0] opcode;
  logic       avail;
  logic       known;
  logic       unused_arg_bits;

  assign opcode = cmd_data[31:28];
  // The word under an in-flight pop is stale; never take it twice.
  assign avail  = !cmd_empty && !cmd_rd_en;
  // Outside IDLE only STOP may leave the FIFO; everything else waits at the head.
  assign accept = avail && ((state == IDLE) || (opcode == OP_STOP));

  assign known = (opcode == OP_SET_PIX) || (opcode == OP_START) ||
                 (opcode == OP_STOP)    || (opcode == OP_SET_GAP);

  assign op_set_pix = accept && (opcode == OP_SET_PIX);
  assign op_start   = accept && (opcode == OP_START);
  assign op_stop    = accept && (opcode == OP_STOP);
  assign op_set_gap = accept && (opcode == OP_SET_GAP);
  assign op_bad     = accept && !known;

  // Arguments are consumed by the top; only the opcode matters here.
  assign unused_arg_bits = ^cmd_data[27:0];

endmodule

// File: rtl/frame_stream_ctrl.sv
// Command-driven frame sequencer between the host command FIFO and the
// read FIFO. Emits n_total frames of FRAME_WORDS words (header + pixels),
// separated by a programmable idle gap; STOP aborts the stream.
// Ports:
//   bus_clk, reset      - clock, asynchronous active-high reset
//   cmd_data/cmd_empty  - command FIFO head (FWFT) and empty flag
//   cmd_rd_en           - registered single-cycle pop pulse
//   out_data/out_wr_en  - read FIFO write data and strobe
//   out_full            - read FIFO full (stalls streaming)
//   busy                - sequencer not in IDLE
//   frames_left         - frames still to send
//   bad_cmd_cnt         - saturating count of unknown opcodes
module frame_stream_ctrl
  import frame_stream_pkg::*;
#(
  parameter int unsigned FRAME_WORDS = 4,
  parameter int unsigned CNT_W       = 22,
  parameter int unsigned GAP_W       = 16
) (
  input  logic             bus_clk,
  input  logic             reset,
  input  logic [31:0]      cmd_data,
  input  logic             cmd_empty,
  output logic             cmd_rd_en,
  output logic [31:0]      out_data,
  output logic             out_wr_en,
  input  logic             out_full,
  output logic             busy,
  output logic [CNT_W-1:0] frames_left,
  output logic [7:0]       bad_cmd_cnt
);

  localparam logic [15:0] LAST_IDX = 16'(FRAME_WORDS - 1);

  state_t             state, state_next;
  logic [15:0]        word_idx, word_idx_next;
  logic [CNT_W-1:0]   frames_left_next;
  logic [CNT_W-1:0]   frames_dec;
  logic [CNT_W-1:0]   n_total;
  logic [GAP_W-1:0]   gap, gap_cnt, gap_cnt_next;
  logic [11:0]        top_pix, bot_pix;
  logic [21:0]        hdr_idx;
  logic [CNT_W-1:0]   start_cnt;
  logic               start_nz;

  logic accept, op_set_pix, op_start, op_stop, op_set_gap, op_bad;

  fsc_cmd_decode u_decode (
    .cmd_data   (cmd_data),
    .cmd_empty  (cmd_empty),
    .cmd_rd_en  (cmd_rd_en),
    .state      (state),
    .accept     (accept),
    .op_set_pix (op_set_pix),
    .op_start   (op_start),
    .op_stop    (op_stop),
    .op_set_gap (op_set_gap),
    .op_bad     (op_bad)
  );

  assign start_cnt  = cmd_data[CNT_W-1:0];
  assign start_nz   = (start_cnt != '0);
  assign frames_dec = frames_left - CNT_W'(1);

  assign busy      = (state != IDLE);
  assign out_wr_en = ((state == HDR) || (state == DATA)) && !out_full;
  assign hdr_idx   = 22'(n_total - frames_left);

  always_comb begin
    out_data = {4'h0, top_pix, 4'h0, bot_pix};
    if (state == HDR) begin
      out_data = {HDR_TAG, 2'b00, hdr_idx};
    end
  end

  always_comb begin
    state_next       = state;
    word_idx_next    = word_idx;
    frames_left_next = frames_left;
    gap_cnt_next     = gap_cnt;
    case (state)
      IDLE: begin
        if (op_start && start_nz) begin
          state_next       = HDR;
          word_idx_next    = '0;
          frames_left_next = start_cnt;
        end
      end
      HDR: begin
        if (out_wr_en) begin
          state_next    = DATA;
          word_idx_next = 16'd1;
        end
      end
      DATA: begin
        if (out_wr_en) begin
          word_idx_next = word_idx + 16'd1;
          if (word_idx == LAST_IDX) begin
            frames_left_next = frames_dec;
            word_idx_next    = '0;
            if (frames_dec == '0) begin
              state_next = IDLE;
            end else if (gap == '0) begin
              state_next = HDR;
            end else begin
              state_next   = GAP;
              gap_cnt_next = gap;
            end
          end
        end
      end
      GAP: begin
        gap_cnt_next = gap_cnt - GAP_W'(1);
        if (gap_cnt <= GAP_W'(1)) begin
          state_next = HDR;
        end
      end
      default: state_next = IDLE;
    endcase
    // STOP wins over any frame bookkeeping; a write in this cycle still lands.
    if (op_stop && (state != IDLE)) begin
      state_next       = IDLE;
      frames_left_next = '0;
    end
  end

  always_ff @(posedge bus_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      word_idx    <= '0;
      frames_left <= '0;
      gap_cnt     <= '0;
      cmd_rd_en   <= 1'b0;
      n_total     <= '0;
      top_pix     <= 12'h015;
      bot_pix     <= 12'h540;
      gap         <= '0;
      bad_cmd_cnt <= '0;
    end else begin
      state       <= state_next;
      word_idx    <= word_idx_next;
      frames_left <= frames_left_next;
      gap_cnt     <= gap_cnt_next;
      cmd_rd_en   <= accept;
      if (op_set_pix) begin
        top_pix <= {4'h0, cmd_data[15:8]};
        bot_pix <= {4'h0, cmd_data[7:0]};
      end
      if (op_start && start_nz) begin
        n_total <= start_cnt;
      end
      if (op_set_gap) begin
        gap <= cmd_data[GAP_W-1:0];
      end
      if (op_bad && (bad_cmd_cnt != 8'hFF)) begin
        bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_stream_ctrl.sv
// Self-checking bench for frame_stream_ctrl: a per-cycle vector table for
// the basic stream and out_full stall, then directed sequences for gap,
// STOP, unknown opcode, zero START and mid-frame reset.
module tb_frame_stream_ctrl;

  logic        bus_clk = 1'b0;
  logic        reset;
  logic [31:0] cmd_data;
  logic        cmd_empty;
  logic        cmd_rd_en;
  logic [31:0] out_data;
  logic        out_wr_en;
  logic        out_full;
  logic        busy;
  logic [21:0] frames_left;
  logic [7:0]  bad_cmd_cnt;

  frame_stream_ctrl #(.FRAME_WORDS(4), .CNT_W(22), .GAP_W(16)) dut (
    .bus_clk     (bus_clk),
    .reset       (reset),
    .cmd_data    (cmd_data),
    .cmd_empty   (cmd_empty),
    .cmd_rd_en   (cmd_rd_en),
    .out_data    (out_data),
    .out_wr_en   (out_wr_en),
    .out_full    (out_full),
    .busy        (busy),
    .frames_left (frames_left),
    .bad_cmd_cnt (bad_cmd_cnt)
  );

  always #5 bus_clk = ~bus_clk;

  // Command FIFO model, first-word fall-through, pops on the DUT pulse.
  logic [31:0] fifo_mem [0:63];
  logic [5:0]  rd_ptr = '0;
  logic [5:0]  wr_ptr = '0;
  assign cmd_data  = fifo_mem[rd_ptr];
  assign cmd_empty = (rd_ptr == wr_ptr);
  always @(posedge bus_clk) if (cmd_rd_en) rd_ptr <= rd_ptr + 6'd1;

  // Write monitor, sampled mid-cycle.
  int          cyc = 0;
  int          wr_n = 0;
  logic [31:0] log_data [0:255];
  int          log_cyc  [0:255];
  always @(posedge bus_clk) cyc <= cyc + 1;
  always @(negedge bus_clk) begin
    if (out_wr_en && wr_n < 256) begin
      log_data[wr_n] = out_data;
      log_cyc[wr_n]  = cyc;
      wr_n = wr_n + 1;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic tick();
    @(posedge bus_clk);
    #1;
  endtask

  typedef struct {
    logic        push;
    logic [31:0] word;
    logic        full;
    logic        exp_rd;
    logic        exp_wr;
    logic [31:0] exp_data;
    logic        exp_busy;
    logic [21:0] exp_fl;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic p, input logic [31:0] w, input logic f, input logic rd,
                     input logic wr, input logic [31:0] d, input logic b, input logic [21:0] fl);
    vec_t v;
    v.push = p; v.word = w; v.full = f; v.exp_rd = rd; v.exp_wr = wr;
    v.exp_data = d; v.exp_busy = b; v.exp_fl = fl;
    vq.push_back(v);
  endtask

  int n0;
  int w_at;

  initial begin
    // Stream of 2 frames after SET_PIX, then 1 frame with a 5-cycle stall.
    add(1, 32'h1000ABCD, 0, 0, 0, 32'h0,        0, 22'd0);
    add(1, 32'h20000002, 0, 1, 0, 32'h0,        0, 22'd0);
    add(0, 32'h0,        0, 0, 0, 32'h0,        0, 22'd0);
    add(0, 32'h0,        0, 1, 1, 32'hA5000000, 1, 22'd2);
    for (int i = 0; i < 3; i++) add(0, 32'h0, 0, 0, 1, 32'h00AB00CD, 1, 22'd2);
    add(0, 32'h0,        0, 0, 1, 32'hA5000001, 1, 22'd1);
    for (int i = 0; i < 3; i++) add(0, 32'h0, 0, 0, 1, 32'h00AB00CD, 1, 22'd1);
    add(0, 32'h0,        0, 0, 0, 32'h0,        0, 22'd0);
    add(1, 32'h20000001, 0, 0, 0, 32'h0,        0, 22'd0);
    add(0, 32'h0,        0, 1, 1, 32'hA5000000, 1, 22'd1);
    add(0, 32'h0,        0, 0, 1, 32'h00AB00CD, 1, 22'd1);
    for (int i = 0; i < 5; i++) add(0, 32'h0, 1, 0, 0, 32'h0, 1, 22'd1);
    for (int i = 0; i < 2; i++) add(0, 32'h0, 0, 0, 1, 32'h00AB00CD, 1, 22'd1);
    add(0, 32'h0,        0, 0, 0, 32'h0,        0, 22'd0);

    reset = 1'b1;
    out_full = 1'b0;
    #12;
    check("rst.rd_en",  {31'b0, cmd_rd_en},   32'h0);
    check("rst.wr_en",  {31'b0, out_wr_en},   32'h0);
    check("rst.busy",   {31'b0, busy},        32'h0);
    check("rst.frames", {10'b0, frames_left}, 32'h0);
    check("rst.bad",    {24'b0, bad_cmd_cnt}, 32'h0);
    check("rst.data",   out_data,             32'h00150540);
    tick();
    reset = 1'b0;
    tick();

    foreach (vq[i]) begin
      if (vq[i].push) push(vq[i].word);
      out_full = vq[i].full;
      @(negedge bus_clk);
      check($sformatf("vec%0d.rd_en", i),  {31'b0, cmd_rd_en},   {31'b0, vq[i].exp_rd});
      check($sformatf("vec%0d.wr_en", i),  {31'b0, out_wr_en},   {31'b0, vq[i].exp_wr});
      check($sformatf("vec%0d.busy", i),   {31'b0, busy},        {31'b0, vq[i].exp_busy});
      check($sformatf("vec%0d.frames", i), {10'b0, frames_left}, {10'b0, vq[i].exp_fl});
      if (vq[i].exp_wr) check($sformatf("vec%0d.data", i), out_data, vq[i].exp_data);
      tick();
    end
    out_full = 1'b0;
    check("table.total_writes", wr_n, 12);

    // Inter-frame gap of 3 idle cycles.
    n0 = wr_n;
    push(32'h40000003);
    push(32'h20000002);
    repeat (20) tick();
    check("gap.writes", wr_n - n0, 8);
    check("gap.busy", {31'b0, busy}, 32'h0);
    if (wr_n - n0 == 8) begin
      for (int k = 1; k < 8; k++)
        check($sformatf("gap.spacing%0d", k), log_cyc[n0 + k] - log_cyc[n0 + k - 1], (k == 4) ? 4 : 1);
      check("gap.hdr0", log_data[n0],     32'hA5000000);
      check("gap.hdr1", log_data[n0 + 4], 32'hA5000001);
      check("gap.pix",  log_data[n0 + 7], 32'h00AB00CD);
    end
    push(32'h40000000);
    repeat (3) tick();

    // STOP during a 100-frame stream; SET_PIX queued behind it.
    push(32'h20000064);
    repeat (10) tick();
    n0 = wr_n;
    push(32'h30000000);
    push(32'h10001122);
    @(negedge bus_clk);
    check("stop.busy_before", {31'b0, busy},      32'h1);
    check("stop.rd_before",   {31'b0, cmd_rd_en}, 32'h0);
    tick();
    @(negedge bus_clk);
    check("stop.busy",   {31'b0, busy},        32'h0);
    check("stop.frames", {10'b0, frames_left}, 32'h0);
    check("stop.wr_en",  {31'b0, out_wr_en},   32'h0);
    check("stop.rd_pop", {31'b0, cmd_rd_en},   32'h1);
    check("stop.last_write", wr_n - n0, 1);
    w_at = wr_n;
    tick();
    @(negedge bus_clk);
    check("stop.rd_gap", {31'b0, cmd_rd_en}, 32'h0);
    tick();
    @(negedge bus_clk);
    check("stop.pix_pop", {31'b0, cmd_rd_en}, 32'h1);
    repeat (5) tick();
    check("stop.no_more_writes", wr_n, w_at);

    // Unknown opcode in IDLE, then START of zero frames.
    push(32'hF0000000);
    @(negedge bus_clk);
    check("bad.rd_now", {31'b0, cmd_rd_en}, 32'h0);
    tick();
    @(negedge bus_clk);
    check("bad.rd_pop", {31'b0, cmd_rd_en},   32'h1);
    check("bad.count",  {24'b0, bad_cmd_cnt}, 32'h1);
    tick();
    @(negedge bus_clk);
    check("bad.rd_once", {31'b0, cmd_rd_en}, 32'h0);
    tick();
    push(32'h20000000);
    tick();
    @(negedge bus_clk);
    check("zero.rd_pop", {31'b0, cmd_rd_en}, 32'h1);
    check("zero.busy",   {31'b0, busy},      32'h0);
    repeat (3) tick();
    check("zero.busy_after", {31'b0, busy}, 32'h0);
    check("zero.no_writes",  wr_n, w_at);
    check("zero.bad_same",   {24'b0, bad_cmd_cnt}, 32'h1);

    // Mid-frame asynchronous reset, then restart from frame 0 with reset pixels.
    push(32'h20000002);
    repeat (3) tick();
    check("mid.pre_wr", {31'b0, out_wr_en}, 32'h1);
    check("mid.pre_data", out_data, 32'h00110022);
    #2;
    reset = 1'b1;
    #1;
    check("mid.wr_en",  {31'b0, out_wr_en},   32'h0);
    check("mid.busy",   {31'b0, busy},        32'h0);
    check("mid.frames", {10'b0, frames_left}, 32'h0);
    check("mid.bad",    {24'b0, bad_cmd_cnt}, 32'h0);
    check("mid.rd_en",  {31'b0, cmd_rd_en},   32'h0);
    check("mid.data",   out_data,             32'h00150540);
    wr_ptr = rd_ptr;
    tick();
    reset = 1'b0;
    tick();
    push(32'h20000001);
    @(negedge bus_clk);
    check("restart.idle", {31'b0, out_wr_en}, 32'h0);
    tick();
    @(negedge bus_clk);
    check("restart.hdr_wr", {31'b0, out_wr_en}, 32'h1);
    check("restart.hdr",    out_data,           32'hA5000000);
    tick();
    @(negedge bus_clk);
    check("restart.pix",    out_data,           32'h00150540);
    repeat (5) tick();
    check("restart.done", {31'b0, busy}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_stream_ctrl.md
# frame_stream_ctrl

Command-driven sequencer between the PC-to-FPGA 32-bit command FIFO and the FPGA-to-PC 32-bit read FIFO on bus_clk. It decodes opcodes from the host and generates a programmed number of fixed-length frames. Each frame is a header word followed by pixel words. Frames are separated by a programmable idle gap, and a STOP command aborts the stream.

## Interface
- FRAME_WORDS, 4: words per frame including the header; legal range is 2..65535.
- CNT_W, 22: width of the frame counter.
- GAP_W, 16: width of the inter-frame gap counter.
- bus_clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high.
- cmd_data  in  32  head of the command FIFO (first-word fall-through).
- cmd_empty  in  1  command FIFO empty.
- cmd_rd_en  out  1  pop pulse for the command FIFO; registered.
- out_data  out  32  data to the read FIFO.
- out_wr_en  out  1  write strobe to the read FIFO.
- out_full  in  1  read FIFO full.
- busy  out  1  high while the state is not IDLE.
- frames_left  out  CNT_W  frames still to send.
- bad_cmd_cnt  out  8  count of unknown opcodes; saturates at 255.

## Operation
- Opcode field is cmd_data[31:28].
  - 0x1 SET_PIX: top_pix[7:0] <= cmd_data[15:8], bot_pix[7:0] <= cmd_data[7:0]. Upper nibbles of the 12-bit pixels are cleared.
  - 0x2 START: n_total <= cmd_data[CNT_W-1:0] and frames_left <= the same value. A value of 0 is a no-op.
  - 0x3 STOP: abort the stream.
  - 0x4 SET_GAP: gap <= cmd_data[GAP_W-1:0].
  - Any other opcode: pop it and increment bad_cmd_cnt.
- Pop rule:
  - cmd_rd_en <= 1 for exactly one cycle when !cmd_empty && !cmd_rd_en and the command is accepted.
  - A command is never popped on two consecutive cycles.
- IDLE accepts every opcode.
- In HDR, DATA and GAP, only STOP is accepted. Any other opcode stays at the FIFO head, unpopped, until the controller returns to IDLE.
- States:
  - IDLE: a START with nonzero count moves to HDR and sets word_idx = 0.
  - HDR: out_data = {8'hA5, 2'b00, frame_idx}, where frame_idx = n_total - frames_left, zero-extended to 22 bits. On a write, move to DATA with word_idx = 1.
  - DATA: out_data = {4'h0, top_pix, 4'h0, bot_pix}. On a write, word_idx increments. The write at word_idx == FRAME_WORDS-1 is the last word of the frame; on that write frames_left decrements, then:
    - if the new frames_left is 0, go to IDLE;
    - else if gap is 0, go to HDR;
    - else go to GAP with gap_cnt = gap.
  - GAP: gap_cnt decrements every cycle; when it reaches 1, go to HDR. No writes occur in GAP.
- STOP accepted in HDR, DATA or GAP:
  - The next state is IDLE and frames_left <= 0.
  - A write happening in the same cycle still completes.
  - The partial frame is not padded.
- Reset values: state IDLE, cmd_rd_en 0, frames_left 0, n_total 0, top_pix 12'h015, bot_pix 12'h540, gap 0, bad_cmd_cnt 0.
- Reset mid-stream returns to IDLE immediately. No further writes occur.

## Timing
- out_wr_en = (state == HDR || state == DATA) && !out_full.
  - Combinational from registered state and out_full only; no path from cmd_data.
  - out_data is combinational from registered state and registers.
- When out_full stays low, frames are back-to-back at 1 word per cycle:
  - FRAME_WORDS cycles per frame, plus gap idle cycles between frames.
- When out_full is high, there is no write and no state change except STOP handling. Streaming resumes on the first cycle out_full is low.
- START latency: START visible at the FIFO head in cycle t gives cmd_rd_en high in t+1 and state HDR in t+1. The first write is in t+1 if !out_full.
- busy rises in the cycle after acceptance. It falls in the cycle after the last write or after the STOP pop.
- frames_left updates on the clock edge that completes a frame's last write.

## Structure
- Shared package frame_stream_pkg holds:
  - opcode localparams OP_SET_PIX, OP_START, OP_STOP, OP_SET_GAP;
  - the header tag 8'hA5;
  - the state enum IDLE, HDR, DATA, GAP.
- One sub-module, fsc_cmd_decode:
  - inputs: cmd_data, cmd_empty, cmd_rd_en, state;
  - outputs: accept and decoded opcode strobes;
  - purely combinational.
- The FSM, counters and pop register stay in the top.

## Test plan
- After reset, SET_PIX 0x1000_ABCD then START 0x2000_0002, with out_full=0 → 8 writes on consecutive cycles:
  - A500_0000, 00AB_00CD, 00AB_00CD, 00AB_00CD;
  - A500_0001, 00AB_00CD ×3.
  - Then busy=0 and frames_left=0.
- SET_GAP 0x4000_0003, then START of 2 frames → exactly 3 cycles with no write between word 3 and the second header.
- out_full held high for 5 cycles in the middle of frame 0 → no writes during those cycles. Resumption continues at the same word_idx, and the total word count is unchanged.
- START of 100 frames, then STOP enqueued → stream ends within 2 cycles of STOP at the FIFO head:
  - frames_left=0 and the state is IDLE;
  - a following SET_PIX is popped only after that.
- Unknown opcode 0xF000_0000 in IDLE → popped once, bad_cmd_cnt=1, no output. START 0x2000_0000 → popped, busy stays 0.
- Reset asserted mid-frame → out_wr_en drops asynchronously with the state and all outputs return to their reset values. A subsequent START restarts at header frame_idx 0.
